// File: rtl/reply_tx_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reply_tx_pkg
// Shared types and constants for the reply transmit buffer.
//   BYTE_W        : width of a reply byte
//   ENTRY_W       : width of one FIFO entry, {last, data}
//   DEFAULT_DEPTH : default number of FIFO entries
//   entry_t       : packed view of a FIFO entry
//   state_t       : transmit FSM state encoding; CSUM_LOAD exists only when
//                   REPLY_TX_CHECKSUM_EN is defined
// ----------------------------------------------------------------------------
package reply_tx_pkg;

    localparam int BYTE_W        = 8;
    localparam int ENTRY_W       = BYTE_W + 1;
    localparam int DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
`ifdef REPLY_TX_CHECKSUM_EN
        ,
        ST_CSUM_LOAD
`endif
    } state_t;

endpackage

// File: rtl/reply_tx_buffer_if.sv
// ----------------------------------------------------------------------------
// reply_tx_buffer_if
// Groups the reply-byte input handshake, the UART byte interface and the
// status outputs of reply_tx_buffer.
//   in_valid/in_data/in_last/in_ready : reply byte stream from cmd_handler
//   tx_busy/tx_start/tx_data          : UART transmitter byte interface
//   fifo_level/overflow/idle          : status
// Modports:
//   slave  : the buffer itself
//   master : the environment (cmd_handler + UART side)
// ----------------------------------------------------------------------------
interface reply_tx_buffer_if #(
    parameter int ADDR_W = $clog2(reply_tx_pkg::DEFAULT_DEPTH)
);
    logic                           in_valid;
    logic [reply_tx_pkg::BYTE_W-1:0] in_data;
    logic                           in_last;
    logic                           in_ready;
    logic                           tx_busy;
    logic                           tx_start;
    logic [reply_tx_pkg::BYTE_W-1:0] tx_data;
    logic [ADDR_W:0]                fifo_level;
    logic                           overflow;
    logic                           idle;

    modport slave (
        input  in_valid, in_data, in_last, tx_busy,
        output in_ready, tx_start, tx_data, fifo_level, overflow, idle
    );

    modport master (
        output in_valid, in_data, in_last, tx_busy,
        input  in_ready, tx_start, tx_data, fifo_level, overflow, idle
    );

endinterface

// File: rtl/reply_tx_buffer_byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
// Synchronous single-clock FIFO, synchronous active-low reset.
//   clkin     : clock
//   reset     : synchronous active-low reset (pointers and level only)
//   wr_en_i   : write request; ignored while full
//   wr_data_i : entry to write
//   rd_en_i   : pop request; ignored while empty
//   rd_data_o : head entry (valid while !empty_o)
//   full_o    : level == DEPTH
//   empty_o   : level == 0
//   level_o   : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 9
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              do_wr, do_rd;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        // Simultaneous write and pop leave the level unchanged.
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is
    // tracked by the level, so stale contents are never observed.
    always_ff @(posedge clkin) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (level_q == FULL_LEVEL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;

endmodule

// File: rtl/reply_tx_buffer.sv
// ----------------------------------------------------------------------------
// reply_tx_buffer
// Queues reply bytes from cmd_handler and feeds them one at a time to the
// UART transmitter, so the reply stream never depends on line speed.
//   clkin : system clock (shared with cmd_handler and the UART)
//   reset : synchronous active-low reset
//   bus   : reply_tx_buffer_if.slave
//           in_valid/in_data/in_last/in_ready - reply byte input
//           tx_busy/tx_start/tx_data          - UART byte interface
//           fifo_level/overflow/idle          - status
// Build option:
//   REPLY_TX_CHECKSUM_EN - after each byte flagged last, send one extra byte
//                          holding the XOR of every byte of that reply.
// ----------------------------------------------------------------------------
module reply_tx_buffer
    import reply_tx_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clkin,
    input  logic              reset,
    reply_tx_buffer_if.slave  bus
);

    state_t            state_q;
    logic              tx_start_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              overflow_q;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [ADDR_W:0]   fifo_level;
    entry_t            head;

`ifdef REPLY_TX_CHECKSUM_EN
    logic              last_q;
    logic [BYTE_W-1:0] csum_acc_q;
    logic              csum_q;    // the byte in flight is the checksum byte
`else
    // The last flag is carried through the FIFO but has no consumer here.
    logic              unused_last;
    assign unused_last = head.last;
`endif

    assign fifo_pop = (state_q == ST_LOAD);
    assign head     = entry_t'(fifo_rd_data);

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_fifo (
        .clkin     (clkin),
        .reset     (reset),
        .wr_en_i   (bus.in_valid),
        .wr_data_i ({bus.in_last, bus.in_data}),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // tx_start is registered: it is raised on entry to START and dropped on
    // the next edge, so it is high for exactly the START cycle.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
`ifdef REPLY_TX_CHECKSUM_EN
            last_q     <= 1'b0;
            csum_acc_q <= '0;
            csum_q     <= 1'b0;
`endif
        end else begin
            if (bus.in_valid && fifo_full) overflow_q <= 1'b1;
            tx_start_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && !bus.tx_busy) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_data_q  <= head.data;
`ifdef REPLY_TX_CHECKSUM_EN
                    last_q     <= head.last;
`endif
                    tx_start_q <= 1'b1;
                    state_q    <= ST_START;
                end
                ST_START: begin
`ifdef REPLY_TX_CHECKSUM_EN
                    // The checksum byte itself must not fold into the next reply.
                    if (!csum_q) csum_acc_q <= csum_acc_q ^ tx_data_q;
`endif
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (bus.tx_busy) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
`ifdef REPLY_TX_CHECKSUM_EN
                        if (last_q && !csum_q) begin
                            state_q <= ST_CSUM_LOAD;
                        end else begin
                            csum_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end
`ifdef REPLY_TX_CHECKSUM_EN
                ST_CSUM_LOAD: begin
                    // Accumulator already holds every byte of the reply,
                    // including the last one folded in during its START.
                    tx_data_q  <= csum_acc_q;
                    csum_acc_q <= '0;
                    csum_q     <= 1'b1;
                    tx_start_q <= 1'b1;
                    state_q    <= ST_START;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_level = fifo_level;
    assign bus.overflow   = overflow_q;
    assign bus.idle       = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_reply_tx_buffer.sv
// ----------------------------------------------------------------------------
// tb_reply_tx_buffer
// Self-checking bench for reply_tx_buffer. A small UART model holds tx_busy
// for 10 cycles after each tx_start; force_busy lets a sequence pin tx_busy
// high. Every tx_start is logged with its byte and cycle number.
// Inputs are driven and outputs compared on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_reply_tx_buffer;

    logic clkin = 1'b0;
    logic reset = 1'b0;
    always #5 clkin = ~clkin;

    reply_tx_buffer_if #(.ADDR_W(4)) bus ();

    reply_tx_buffer #(
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- environment ----------------
    int   cyc = 0;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;

    always @(posedge clkin) cyc <= cyc + 1;

    // UART model: busy for 10 cycles after each tx_start; reset does not abort it.
    always @(posedge clkin) begin
        if (bus.tx_start)       busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = force_busy || (busy_cnt != 0);

    logic [7:0] tx_log [$];
    int         tx_cyc [$];
    always @(negedge clkin) begin
        if (bus.tx_start) begin
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < tx_log.size()) ? int'(tx_log[i]) : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < tx_cyc.size()) ? tx_cyc[i] : -1;
    endfunction

    task automatic clear_log();
        tx_log.delete();
        tx_cyc.delete();
    endtask

    // Offer one byte for one cycle; returns at the next falling edge.
    task automatic write_byte(input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clkin);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait until FIFO empty, FSM idle and UART quiet, within a cycle budget.
    task automatic wait_quiet(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clkin);
            if (bus.idle && !bus.tx_busy) break;
        end
        check({name, " quiet before timeout"}, int'(i < budget), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] csum;   // XOR of the reply so far, used only with the checksum build
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         wr_cyc, rel_cyc, exp_pulses;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 8'h00};
        vecs[2] = '{8'h00, 1'b1, 8'h3C};
        vecs[3] = '{8'hFF, 1'b0, 8'h00};
        vecs[4] = '{8'h81, 1'b1, 8'h7E};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;

        // Reset state
        repeat (2) @(negedge clkin);
        check("reset in_ready",   int'(bus.in_ready),   1);
        check("reset idle",       int'(bus.idle),       1);
        check("reset fifo_level", int'(bus.fifo_level), 0);
        check("reset tx_start",   int'(bus.tx_start),   0);
        check("reset tx_data",    int'(bus.tx_data),    0);
        check("reset overflow",   int'(bus.overflow),   0);
        reset = 1'b1;
        @(negedge clkin);

        // Table: single bytes into an empty FIFO, tx_start at N+3.
        for (int i = 0; i < 5; i++) begin
            clear_log();
            wr_cyc = cyc;
            write_byte(vecs[i].data, vecs[i].last);
            wait_quiet($sformatf("vec%0d", i), 100);
            @(negedge clkin);
`ifdef REPLY_TX_CHECKSUM_EN
            exp_pulses = vecs[i].last ? 2 : 1;
`else
            exp_pulses = 1;
`endif
            check($sformatf("vec%0d pulses", i),  tx_log.size(), exp_pulses);
            check($sformatf("vec%0d tx_data", i), log_at(0), int'(vecs[i].data));
            check($sformatf("vec%0d latency", i), cyc_at(0) - wr_cyc, 3);
`ifdef REPLY_TX_CHECKSUM_EN
            if (vecs[i].last)
                check($sformatf("vec%0d checksum", i), log_at(1), int'(vecs[i].csum));
`endif
            check($sformatf("vec%0d idle", i),     int'(bus.idle),     1);
            check($sformatf("vec%0d overflow", i), int'(bus.overflow), 0);
        end

        // Multi-byte reply, then a one-byte reply.
        clear_log();
`ifdef REPLY_TX_CHECKSUM_EN
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h70, 8'h01, 8'h01};
`else
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h01};
`endif
        write_byte(8'h12, 1'b0);
        write_byte(8'h34, 1'b0);
        write_byte(8'h56, 1'b1);
        wait_quiet("reply3", 300);
        write_byte(8'h01, 1'b1);
        wait_quiet("reply1", 100);
        check("reply seq count", tx_log.size(), exp_q.size());
        foreach (exp_q[k])
            check($sformatf("reply seq byte%0d", k), log_at(k), int'(exp_q[k]));

        // Fill while the UART is busy, then overflow with a 17th byte.
        clear_log();
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i), 1'b0);
        check("full in_ready",   int'(bus.in_ready),   0);
        check("full level",      int'(bus.fifo_level), 16);
        check("full overflow",   int'(bus.overflow),   0);
        write_byte(8'hEE, 1'b0);
        check("ovf level",       int'(bus.fifo_level), 16);
        check("ovf overflow",    int'(bus.overflow),   1);
        check("ovf no tx_start", tx_log.size(), 0);
        force_busy = 1'b0;
        wait_quiet("drain16", 400);
        check("drain count", tx_log.size(), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("drain byte%0d", i), log_at(i), 'h40 + i);
        check("drain overflow sticky", int'(bus.overflow), 1);

        // Write coinciding with the LOAD pop at level 5.
        clear_log();
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i), 1'b0);
        check("lvl5 before", int'(bus.fifo_level), 5);
        force_busy = 1'b0;      // IDLE sees busy low this cycle, LOAD next
        @(negedge clkin);
        write_byte(8'h55, 1'b0);
        check("lvl5 after pop+write", int'(bus.fifo_level), 5);
        check("lvl5 in START",        int'(bus.tx_start),   1);
        wait_quiet("lvl5 drain", 200);
        check("lvl5 count", tx_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("lvl5 byte%0d", i), log_at(i), 'h50 + i);

        // Reset while in WAIT_DONE with 4 bytes queued.
        for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), 1'b0);
        repeat (3) @(negedge clkin);
        check("rst pre level", int'(bus.fifo_level), 4);
        check("rst pre busy",  int'(bus.tx_busy),    1);
        clear_log();
        reset = 1'b0;
        @(negedge clkin);
        reset = 1'b1;
        check("rst level",    int'(bus.fifo_level), 0);
        check("rst tx_start", int'(bus.tx_start),   0);
        check("rst overflow", int'(bus.overflow),   0);
        check("rst idle",     int'(bus.idle),       1);
        repeat (40) @(negedge clkin);
        check("rst no tx_start", tx_log.size(), 0);

        // Byte arrives while UART busy: nothing until busy is released.
        clear_log();
        force_busy = 1'b1;
        write_byte(8'h77, 1'b1);
        repeat (6) @(negedge clkin);
        check("busy no tx_start", tx_log.size(), 0);
        check("busy level",       int'(bus.fifo_level), 1);
        force_busy = 1'b0;
        rel_cyc = cyc;          // busy first sampled low at the end of this cycle
        wait_quiet("busy release", 100);
        check("busy release data",    log_at(0), 'h77);
        check("busy release latency", cyc_at(0) - rel_cyc, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
